ldpc_bitflip_ctrl: RTL and testbench

//  Iterative hard-decision bit-flipping decoder controller for the (6,3) LDPC code.

---
 rtl/ldpc_pkg.sv | 10 +
 rtl/ldpc_syn_count.sv | 30 +++
 rtl/ldpc_bitflip_ctrl.sv | 96 +++++++++
 tb/tb_ldpc_bitflip_ctrl.sv | 139 +++++++++++++
 4 files changed

// File: rtl/ldpc_pkg.sv
// ldpc_pkg: shared sizes, default parity-check rows and controller state encoding
// for the (6,3) LDPC bit-flipping decoder.
package ldpc_pkg;
    localparam int N = 6;
    localparam int M = 3;
    localparam logic [N-1:0] H0_DEF = 6'b001011;
    localparam logic [N-1:0] H1_DEF = 6'b010101;
    localparam logic [N-1:0] H2_DEF = 6'b100110;
    typedef enum logic [1:0] {IDLE, SYND, FLIP, DONE} state_t;
endpackage

// File: rtl/ldpc_syn_count.sv
// ldpc_syn_count: combinational syndrome of a word, plus the flip mask derived from a
// registered syndrome (bits sitting in the largest number of unsatisfied checks).
module ldpc_syn_count
    import ldpc_pkg::*;
#(
    parameter logic [N-1:0] H0 = H0_DEF,
    parameter logic [N-1:0] H1 = H1_DEF,
    parameter logic [N-1:0] H2 = H2_DEF
) (
    input  logic [N-1:0] i_cw,
    input  logic [M-1:0] i_syn,
    output logic [M-1:0] o_syn,
    output logic [N-1:0] o_flip
);
    logic [1:0] w_cnt [N];
    logic [1:0] w_mx;

    assign o_syn = {^(i_cw & H2), ^(i_cw & H1), ^(i_cw & H0)};

    always_comb begin
        w_mx = '0;
        for (int i = 0; i < N; i++) begin
            w_cnt[i] = 2'(i_syn[0] & H0[i]) + 2'(i_syn[1] & H1[i]) + 2'(i_syn[2] & H2[i]);
            w_mx = (w_cnt[i] > w_mx) ? w_cnt[i] : w_mx;
        end
        // a zero syndrome gives mx==0, which would otherwise select every bit
        for (int i = 0; i < N; i++)
            o_flip[i] = (|i_syn) && (w_cnt[i] == w_mx);
    end
endmodule

// File: rtl/ldpc_bitflip_ctrl.sv
// ldpc_bitflip_ctrl: iterative hard-decision bit-flipping decoder controller, (6,3) LDPC.
// Define LDPC_EARLY_STOP_EN to finish as soon as the syndrome is zero (variable latency).
module ldpc_bitflip_ctrl
    import ldpc_pkg::*;
#(
    parameter int MAX_ITER = 8,
    parameter logic [N-1:0] H0 = H0_DEF,
    parameter logic [N-1:0] H1 = H1_DEF,
    parameter logic [N-1:0] H2 = H2_DEF,
    localparam int IW = (MAX_ITER > 0) ? $clog2(MAX_ITER + 1) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_in_valid,
    output logic          o_in_ready,
    input  logic [N-1:0]  i_in_cw,
    output logic          o_out_valid,
    input  logic          i_out_ready,
    output logic [N-1:0]  o_out_cw,
    output logic          o_out_ok,
    output logic [IW-1:0] o_out_iter
);
    localparam logic [IW-1:0] MAX_I = IW'(MAX_ITER);

    state_t        r_state;
    logic [N-1:0]  r_cw;
    logic [M-1:0]  r_syn;
    logic [IW-1:0] r_iter;
    logic [N-1:0]  r_out_cw;
    logic          r_out_ok;
    logic [IW-1:0] r_out_iter;
    logic          r_out_valid;
    logic [M-1:0]  w_syn;
    logic [N-1:0]  w_flip;
    logic          w_stop;

    ldpc_syn_count #(.H0(H0), .H1(H1), .H2(H2)) u_syn_count (
        .i_cw  (r_cw),
        .i_syn (r_syn),
        .o_syn (w_syn),
        .o_flip(w_flip)
    );

`ifdef LDPC_EARLY_STOP_EN
    assign w_stop = (r_iter == MAX_I) || (r_syn == '0);
`else
    assign w_stop = (r_iter == MAX_I);
`endif

    assign o_in_ready  = (r_state == IDLE);
    assign o_out_valid = r_out_valid;
    assign o_out_cw    = r_out_cw;
    assign o_out_ok    = r_out_ok;
    assign o_out_iter  = r_out_iter;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cw        <= '0;
            r_syn       <= '0;
            r_iter      <= '0;
            r_out_cw    <= '0;
            r_out_ok    <= 1'b0;
            r_out_iter  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (i_in_valid) begin
                    r_cw    <= i_in_cw;
                    r_iter  <= '0;
                    r_state <= SYND;
                end
                SYND: begin
                    r_syn   <= w_syn;
                    r_state <= FLIP;
                end
                FLIP: if (w_stop) begin
                    r_out_cw    <= r_cw;
                    r_out_ok    <= (r_syn == '0);
                    r_out_iter  <= r_iter;
                    r_out_valid <= 1'b1;
                    r_state     <= DONE;
                end else begin
                    r_cw    <= r_cw ^ w_flip;
                    r_iter  <= r_iter + 1'b1;
                    r_state <= SYND;
                end
                DONE: if (i_out_ready) begin
                    r_out_valid <= 1'b0;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ldpc_bitflip_ctrl.sv
// tb_ldpc_bitflip_ctrl: directed vectors against three decoder instances
// (MAX_ITER = 8, 0 and 1); expectations follow the build's early-stop setting.
module tb_ldpc_bitflip_ctrl;
`ifdef LDPC_EARLY_STOP_EN
    localparam bit ES = 1'b1;
`else
    localparam bit ES = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] iv;
    logic [5:0] cw;
    logic       ordy;
    logic [2:0] ir, ov;
    logic [5:0] ocw0, ocw1, ocw2;
    logic       ok0, ok1, ok2;
    logic [3:0] it0;
    logic       it1, it2;
    int         n_chk = 0;
    int         n_bad = 0;

    always #5 clk = ~clk;

    ldpc_bitflip_ctrl #(.MAX_ITER(8)) u_d0 (
        .clk(clk), .rst_n(rst_n), .i_in_valid(iv[0]), .o_in_ready(ir[0]), .i_in_cw(cw),
        .o_out_valid(ov[0]), .i_out_ready(ordy), .o_out_cw(ocw0), .o_out_ok(ok0), .o_out_iter(it0)
    );
    ldpc_bitflip_ctrl #(.MAX_ITER(0)) u_d1 (
        .clk(clk), .rst_n(rst_n), .i_in_valid(iv[1]), .o_in_ready(ir[1]), .i_in_cw(cw),
        .o_out_valid(ov[1]), .i_out_ready(ordy), .o_out_cw(ocw1), .o_out_ok(ok1), .o_out_iter(it1)
    );
    ldpc_bitflip_ctrl #(.MAX_ITER(1)) u_d2 (
        .clk(clk), .rst_n(rst_n), .i_in_valid(iv[2]), .o_in_ready(ir[2]), .i_in_cw(cw),
        .o_out_valid(ov[2]), .i_out_ready(ordy), .o_out_cw(ocw2), .o_out_ok(ok2), .o_out_iter(it2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // called just after a rising edge; latency counted in edges from the accept edge
    task automatic run(input int d, input logic [5:0] c, input logic [5:0] e_cw,
                       input logic e_ok, input int e_it);
        int lat;
        logic [5:0] g_cw;
        logic g_ok;
        logic [3:0] g_it;
        check($sformatf("in_ready%0d", d), 32'(ir[d]), 1);
        cw = c;
        iv[d] = 1'b1;
        @(posedge clk);
        #1 iv[d] = 1'b0;
        lat = 0;
        while (!ov[d] && lat < 50) begin
            @(posedge clk);
            #1 lat++;
        end
        g_cw = (d == 0) ? ocw0 : (d == 1) ? ocw1 : ocw2;
        g_ok = (d == 0) ? ok0 : (d == 1) ? ok1 : ok2;
        g_it = (d == 0) ? it0 : (d == 1) ? 4'(it1) : 4'(it2);
        check($sformatf("lat%0d_%b", d, c), lat, 2 + 2 * e_it);
        check($sformatf("cw%0d_%b", d, c), 32'(g_cw), 32'(e_cw));
        check($sformatf("ok%0d_%b", d, c), 32'(g_ok), 32'(e_ok));
        check($sformatf("iter%0d_%b", d, c), 32'(g_it), e_it);
        if (ordy) begin
            @(posedge clk);
            #1 check($sformatf("drop%0d", d), 32'(ov[d]), 0);
            check($sformatf("idle%0d", d), 32'(ir[d]), 1);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        iv    = '0;
        cw    = '0;
        ordy  = 1'b1;
        repeat (2) @(posedge clk);
        #1 check("rst_ov", 32'(ov), 0);
        check("rst_ir", 32'(ir), 32'h7);
        check("rst_cw", 32'(ocw0), 0);
        check("rst_iter", 32'(it0), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run(0, 6'b000000, 6'b000000, 1'b1, ES ? 0 : 8);
        run(0, 6'b000001, 6'b000000, 1'b1, ES ? 1 : 8);
        run(0, 6'b000100, 6'b000000, 1'b1, ES ? 1 : 8);
        run(0, 6'b000011, 6'b000111, 1'b1, ES ? 1 : 8);
        run(0, 6'b001000, 6'b000111, 1'b1, ES ? 2 : 8);
        run(1, 6'b000001, 6'b000001, 1'b0, 0);
        run(1, 6'b000000, 6'b000000, 1'b1, 0);
        run(2, 6'b001000, 6'b000011, 1'b0, 1);
        run(2, 6'b000000, 6'b000000, 1'b1, ES ? 0 : 1);
        // sink stalls in DONE while the source keeps offering a new word
        ordy = 1'b0;
        run(0, 6'b000001, 6'b000000, 1'b1, ES ? 1 : 8);
        cw = 6'b111111;
        iv[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1 check("hold_ov", 32'(ov[0]), 1);
            check("hold_cw", 32'(ocw0), 0);
            check("hold_ir", 32'(ir[0]), 0);
        end
        ordy = 1'b1;
        @(posedge clk);
        #1 iv[0] = 1'b0;
        check("rel_ov", 32'(ov[0]), 0);
        check("rel_ir", 32'(ir[0]), 1);
        repeat (4) @(posedge clk);
        #1 check("no_accept", 32'(ov[0]), 0);
        check("no_accept_ir", 32'(ir[0]), 1);
        // leave nonzero outputs behind, then reset in the middle of a decode
        run(0, 6'b001000, 6'b000111, 1'b1, ES ? 2 : 8);
        cw = 6'b000001;
        iv[0] = 1'b1;
        @(posedge clk);
        #1 iv[0] = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1 check("mid_rst_ov", 32'(ov[0]), 0);
        check("mid_rst_cw", 32'(ocw0), 0);
        check("mid_rst_ok", 32'(ok0), 0);
        check("mid_rst_iter", 32'(it0), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        check("post_rst_ir", 32'(ir[0]), 1);
        repeat (6) @(posedge clk);
        #1 check("post_rst_ov", 32'(ov[0]), 0);
        run(0, 6'b000000, 6'b000000, 1'b1, ES ? 0 : 8);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
